// File: rtl/bsg_manycore_host_req_sched_pkg.sv
// Shared types for the host request scheduler.
package bsg_manycore_host_req_sched_pkg;

   typedef enum logic [1:0] {
      eWAIT_TAG = 2'd0,
      eRUN      = 2'd1,
      eFENCE    = 2'd2
   } host_req_sched_state_e;

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter: searches from the priority pointer and moves the
// pointer to winner+1 whenever the winner is dequeued.
module bsg_arb_round_robin #(
   parameter int unsigned width_p = 2
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               grants_en_i,
   input  logic [width_p-1:0] reqs_i,
   output logic [width_p-1:0] grants_o,
   output logic               v_o,
   input  logic               yumi_i
);

   localparam int unsigned ptr_w_lp = (width_p > 1) ? $clog2(width_p) : 1;

   logic [ptr_w_lp-1:0] r_ptr;
   logic [ptr_w_lp-1:0] w_winner;
   logic [ptr_w_lp-1:0] w_idx;
   logic                w_found;

   always_comb begin
      w_winner = '0;
      w_idx    = '0;
      w_found  = 1'b0;
      grants_o = '0;
      for (int k = 0; k < width_p; k++) begin
         w_idx = ptr_w_lp'((32'(r_ptr) + 32'(k)) % width_p);
         if (!w_found && reqs_i[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end
      if (grants_en_i && w_found) grants_o[w_winner] = 1'b1;
   end

   assign v_o = w_found;

   always_ff @(posedge clk_i) begin
      if (reset_i)
         r_ptr <= '0;
      else if (yumi_i && w_found)
         r_ptr <= (w_winner == ptr_w_lp'(width_p - 1)) ? '0 : w_winner + ptr_w_lp'(1);
   end

endmodule

// File: rtl/bsg_manycore_host_req_scheduler.sv
// Credit-gated round-robin scheduler sharing the host link endpoint between
// host-side request sources, with tag-programming gate and drain fence.
module bsg_manycore_host_req_scheduler
   import bsg_manycore_host_req_sched_pkg::*;
#(
   parameter int unsigned num_req_p      = 2,
   parameter int unsigned packet_width_p = 128,
   parameter int unsigned max_credits_p  = 16,
   parameter int unsigned credit_width_p = $clog2(max_credits_p + 1)
) (
   input  logic                                clk_i,
   input  logic                                reset_i,
   input  logic                                reset_done_i,
   input  logic [num_req_p-1:0]                req_v_i,
   input  logic [num_req_p*packet_width_p-1:0] req_packet_i,
   output logic [num_req_p-1:0]                req_yumi_o,
   output logic                                pkt_v_o,
   output logic [packet_width_p-1:0]           pkt_o,
   input  logic                                pkt_ready_i,
   input  logic                                credit_return_i,
   input  logic                                fence_req_i,
   output logic                                fence_done_o,
   output logic [credit_width_p-1:0]           credits_used_o,
   output logic                                idle_o
);

   host_req_sched_state_e r_state, w_state_next;

   logic                      r_pkt_v;
   logic [packet_width_p-1:0] r_pkt;
   logic [credit_width_p-1:0] r_credits;

   logic                      w_fence_done;
   logic                      w_grant_en;
   logic                      w_grant;
   logic                      w_arb_v;
   logic [num_req_p-1:0]      w_yumi;
   logic [packet_width_p-1:0] w_pkt_sel;

   always_ff @(posedge clk_i) begin
      if (reset_i) r_state <= eWAIT_TAG;
      else         r_state <= w_state_next;
   end

   // Fence completes once the output register and all outstanding credits drain.
   always_comb begin
      w_state_next = r_state;
      w_fence_done = 1'b0;
      case (r_state)
         eWAIT_TAG: if (reset_done_i) w_state_next = eRUN;
         eRUN:      if (fence_req_i)  w_state_next = eFENCE;
         eFENCE: begin
            if (!r_pkt_v && (r_credits == '0)) begin
               w_state_next = eRUN;
               w_fence_done = 1'b1;
            end
         end
         default:   w_state_next = eWAIT_TAG;
      endcase
   end

   assign w_grant_en = (r_state == eRUN) && !fence_req_i && (|req_v_i)
                     && (r_credits < credit_width_p'(max_credits_p))
                     && (!r_pkt_v || pkt_ready_i);
   assign w_grant    = w_grant_en && w_arb_v;

   bsg_arb_round_robin #(
      .width_p (num_req_p)
   ) u_arb (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .grants_en_i (w_grant_en),
      .reqs_i      (req_v_i),
      .grants_o    (w_yumi),
      .v_o         (w_arb_v),
      .yumi_i      (w_grant)
   );

   always_comb begin
      w_pkt_sel = '0;
      for (int i = 0; i < num_req_p; i++)
         if (w_yumi[i]) w_pkt_sel = req_packet_i[i*packet_width_p +: packet_width_p];
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_pkt_v <= 1'b0;
         r_pkt   <= '0;
      end else if (w_grant) begin
         r_pkt_v <= 1'b1;
         r_pkt   <= w_pkt_sel;
      end else if (pkt_ready_i) begin
         r_pkt_v <= 1'b0;
      end
   end

   // Grant and return in the same cycle cancel; returns saturate at zero.
   always_ff @(posedge clk_i) begin
      if (reset_i)
         r_credits <= '0;
      else if (w_grant && !credit_return_i)
         r_credits <= r_credits + credit_width_p'(1);
      else if (!w_grant && credit_return_i && (r_credits != '0))
         r_credits <= r_credits - credit_width_p'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i)
         assert (!(credit_return_i && (r_credits == '0)))
            else $error("credit returned with no requests outstanding");
   end

   assign req_yumi_o     = w_yumi;
   assign pkt_v_o        = r_pkt_v;
   assign pkt_o          = r_pkt;
   assign fence_done_o   = w_fence_done;
   assign credits_used_o = r_credits;
   assign idle_o         = !r_pkt_v && (r_credits == '0);

endmodule

// File: tb/tb_bsg_manycore_host_req_scheduler.sv
// Directed bench for bsg_manycore_host_req_scheduler: tag gating, fairness,
// credit ceiling, backpressure, fence and mid-operation reset.
module tb_bsg_manycore_host_req_scheduler;

   logic         clk_i = 1'b0;
   logic         reset_i;
   logic         reset_done_i;
   logic [1:0]   req_v_i;
   logic [255:0] req_packet_i;
   logic [1:0]   req_yumi_o;
   logic         pkt_v_o;
   logic [127:0] pkt_o;
   logic         pkt_ready_i;
   logic         credit_return_i;
   logic         fence_req_i;
   logic         fence_done_o;
   logic [4:0]   credits_used_o;
   logic         idle_o;

   logic [127:0] p0, p1, p0_old;
   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   assign req_packet_i = {p1, p0};

   always #5 clk_i = ~clk_i;

   bsg_manycore_host_req_scheduler dut (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .reset_done_i    (reset_done_i),
      .req_v_i         (req_v_i),
      .req_packet_i    (req_packet_i),
      .req_yumi_o      (req_yumi_o),
      .pkt_v_o         (pkt_v_o),
      .pkt_o           (pkt_o),
      .pkt_ready_i     (pkt_ready_i),
      .credit_return_i (credit_return_i),
      .fence_req_i     (fence_req_i),
      .fence_done_o    (fence_done_o),
      .credits_used_o  (credits_used_o),
      .idle_o          (idle_o)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk_i);
   endtask

   initial begin
      reset_i = 1'b1; reset_done_i = 1'b0; req_v_i = 2'b00; pkt_ready_i = 1'b0;
      credit_return_i = 1'b0; fence_req_i = 1'b0;
      p0 = {8'hA0, 120'h0123_4567_89AB}; p1 = {8'hB1, 120'hFEDC_BA98_7654};
      step(); #1;
      chk("rst_pkt_v", 128'(pkt_v_o), 128'd0);
      chk("rst_pkt", pkt_o, 128'd0);
      chk("rst_yumi", 128'(req_yumi_o), 128'd0);
      chk("rst_fence_done", 128'(fence_done_o), 128'd0);
      chk("rst_credits", 128'(credits_used_o), 128'd0);
      chk("rst_idle", 128'(idle_o), 128'd1);

      // Tag gating
      step(); reset_i = 1'b0; req_v_i = 2'b11; pkt_ready_i = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (c > 0) step();
         #1 chk("tag_gate_yumi", 128'(req_yumi_o), 128'd0);
      end
      step(); reset_done_i = 1'b1; #1 chk("tag_rise_yumi", 128'(req_yumi_o), 128'd0);
      step(); reset_done_i = 1'b0; #1 chk("tag_first_yumi", 128'(req_yumi_o), 128'b01);
      step(); req_v_i = 2'b00; credit_return_i = 1'b1; #1;
      chk("tag_pkt_v", 128'(pkt_v_o), 128'd1);
      chk("tag_pkt", pkt_o, p0);
      chk("tag_credits", 128'(credits_used_o), 128'd1);
      step(); credit_return_i = 1'b0; #1;
      chk("tag_drain_credits", 128'(credits_used_o), 128'd0);
      chk("tag_drain_idle", 128'(idle_o), 128'd1);

      // Fairness: pointer sits at 1 after the first grant
      for (int k = 0; k < 8; k++) begin
         step(); req_v_i = 2'b11; credit_return_i = (k > 0); #1;
         chk("fair_yumi", 128'(req_yumi_o), (k % 2 == 0) ? 128'b10 : 128'b01);
         chk("fair_credits", 128'(credits_used_o), (k == 0) ? 128'd0 : 128'd1);
         if (k > 0) chk("fair_pkt", pkt_o, (k % 2 == 1) ? p1 : p0);
      end
      step(); req_v_i = 2'b00; credit_return_i = 1'b1; #1;
      chk("fair_end_yumi", 128'(req_yumi_o), 128'd0);
      chk("fair_end_pkt", pkt_o, p0);
      step(); credit_return_i = 1'b0; #1 chk("fair_end_idle", 128'(idle_o), 128'd1);

      // Credit ceiling
      for (int k = 0; k < 16; k++) begin
         step(); req_v_i = 2'b11; #1;
         chk("ceil_yumi", 128'(req_yumi_o), (k % 2 == 0) ? 128'b10 : 128'b01);
      end
      for (int k = 0; k < 3; k++) begin
         step(); #1;
         chk("ceil_full_yumi", 128'(req_yumi_o), 128'd0);
         chk("ceil_full_credits", 128'(credits_used_o), 128'd16);
      end
      step(); credit_return_i = 1'b1; #1 chk("ceil_ret_no_bypass", 128'(req_yumi_o), 128'd0);
      step(); credit_return_i = 1'b0; #1;
      chk("ceil_one_more_yumi", 128'(req_yumi_o), 128'b10);
      chk("ceil_one_more_credits", 128'(credits_used_o), 128'd15);
      step(); #1;
      chk("ceil_refull_yumi", 128'(req_yumi_o), 128'd0);
      chk("ceil_refull_credits", 128'(credits_used_o), 128'd16);
      req_v_i = 2'b00;
      for (int k = 0; k < 16; k++) begin
         step(); credit_return_i = 1'b1;
      end
      step(); credit_return_i = 1'b0; #1;
      chk("ceil_drain_credits", 128'(credits_used_o), 128'd0);
      chk("ceil_drain_idle", 128'(idle_o), 128'd1);

      // Backpressure
      step(); req_v_i = 2'b11; pkt_ready_i = 1'b0; #1 chk("bp_first_yumi", 128'(req_yumi_o), 128'b01);
      p0_old = p0;
      for (int k = 0; k < 5; k++) begin
         step(); if (k == 0) p0 = {8'hC2, 120'h5555_AAAA}; #1;
         chk("bp_hold_yumi", 128'(req_yumi_o), 128'd0);
         chk("bp_hold_pkt_v", 128'(pkt_v_o), 128'd1);
         chk("bp_hold_pkt", pkt_o, p0_old);
      end
      step(); pkt_ready_i = 1'b1; #1 chk("bp_drain_grant", 128'(req_yumi_o), 128'b10);
      step(); req_v_i = 2'b00; credit_return_i = 1'b1; #1;
      chk("bp_next_pkt", pkt_o, p1);
      chk("bp_credits", 128'(credits_used_o), 128'd2);
      step(); step(); credit_return_i = 1'b0; #1 chk("bp_idle", 128'(idle_o), 128'd1);

      // Fence with three outstanding
      for (int k = 0; k < 3; k++) begin
         step(); req_v_i = 2'b11; #1;
         chk("fence_pre_yumi", 128'(req_yumi_o), (k % 2 == 0) ? 128'b01 : 128'b10);
      end
      step(); fence_req_i = 1'b1; #1;
      chk("fence_req_yumi", 128'(req_yumi_o), 128'd0);
      chk("fence_req_credits", 128'(credits_used_o), 128'd3);
      for (int j = 0; j < 5; j++) begin
         step(); fence_req_i = 1'b0; credit_return_i = (j % 2 == 0); #1;
         chk("fence_hold_yumi", 128'(req_yumi_o), 128'd0);
         chk("fence_hold_done", 128'(fence_done_o), 128'd0);
      end
      step(); credit_return_i = 1'b0; #1;
      chk("fence_done", 128'(fence_done_o), 128'd1);
      chk("fence_done_yumi", 128'(req_yumi_o), 128'd0);
      step(); #1;
      chk("fence_resume_yumi", 128'(req_yumi_o), 128'b10);
      chk("fence_resume_done", 128'(fence_done_o), 128'd0);

      // Build 5 outstanding, leaving the pointer at 1, then reset
      step(); #1 chk("rmid_yumi_a", 128'(req_yumi_o), 128'b01);
      step(); #1 chk("rmid_yumi_b", 128'(req_yumi_o), 128'b10);
      step(); #1 chk("rmid_yumi_c", 128'(req_yumi_o), 128'b01);
      step(); req_v_i = 2'b01; #1 chk("rmid_yumi_d", 128'(req_yumi_o), 128'b01);
      step(); req_v_i = 2'b00; pkt_ready_i = 1'b0; #1;
      chk("rmid_pre_credits", 128'(credits_used_o), 128'd5);
      chk("rmid_pre_pkt_v", 128'(pkt_v_o), 128'd1);
      reset_i = 1'b1;
      step(); reset_i = 1'b0; req_v_i = 2'b11; pkt_ready_i = 1'b1;
      fence_req_i = 1'b1; reset_done_i = 1'b1; #1;
      chk("rmid_pkt_v", 128'(pkt_v_o), 128'd0);
      chk("rmid_pkt", pkt_o, 128'd0);
      chk("rmid_credits", 128'(credits_used_o), 128'd0);
      chk("rmid_idle", 128'(idle_o), 128'd1);
      chk("rmid_wait_tag_yumi", 128'(req_yumi_o), 128'd0);
      step(); fence_req_i = 1'b0; reset_done_i = 1'b0; #1;
      chk("rmid_ptr_reset_yumi", 128'(req_yumi_o), 128'b01);

      // Fence while already idle
      step(); req_v_i = 2'b00; credit_return_i = 1'b1; #1 chk("idle_fence_credits", 128'(credits_used_o), 128'd1);
      step(); credit_return_i = 1'b0; fence_req_i = 1'b1; #1;
      chk("idle_fence_idle", 128'(idle_o), 128'd1);
      chk("idle_fence_no_early_done", 128'(fence_done_o), 128'd0);
      step(); fence_req_i = 1'b0; #1 chk("idle_fence_done", 128'(fence_done_o), 128'd1);
      step(); #1 chk("idle_fence_done_pulse", 128'(fence_done_o), 128'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
